avmm_lane_master: RTL and testbench
===================================

// Module: avmm_lane_master
// PURPOSE
//  Avalon-MM master that issues single byte/half/word accesses to 32-bit byte-enabled registers.
//  Converts a right-justified command (addr, size, data) into a word-aligned bus cycle:
//  byteenable generation, write-lane steering, read-lane extraction.
//  Sits between a local command source (CPU bridge / test sequencer) and the register fabric.
//  Uses pipelined reads (readdatavalid).
// PARAMETERS
//  ADDR_W   32   byte-address width of cmd_addr and avm_address
//  TIMEOUT  255  max cycles in BUS+RDWAIT before abort with error; 0 disables timeout
// PORTS
//  clock              in   1       clock; all logic on posedge
//  reset_n            in   1       reset, synchronous, active-low
//  cmd_valid          in   1       command present
//  cmd_ready          out  1       command accepted when cmd_valid & cmd_ready at posedge
//  cmd_write          in   1       1 = write, 0 = read
//  cmd_size           in   2       00 byte, 01 half, 10 word, 11 illegal
//  cmd_addr           in   ADDR_W  byte address
//  cmd_wdata          in   32      write data, right-justified
//  rsp_valid          out  1       response present; held until rsp_ready
//  rsp_ready          in   1       response consumed when rsp_valid & rsp_ready at posedge
//  rsp_rdata          out  32      read data, right-justified, zero-extended; 0 for writes/errors
//  rsp_err            out  1       misaligned/illegal size, or timeout
//  avm_address        out  ADDR_W  {cmd_addr[ADDR_W-1:2], 2'b00}
//  avm_byteenable     out  4       lane enables
//  avm_write          out  1       write request
//  avm_read           out  1       read request
//  avm_writedata      out  32      lane-steered write data
//  avm_waitrequest    in   1       slave stall
//  avm_readdata       in   32      read data
//  avm_readdatavalid  in   1       read data valid
// BEHAVIOUR
//  - Reset: reset_n=0 at a posedge -> state IDLE.
//    All registered outputs 0: avm_*, rsp_valid, rsp_rdata, rsp_err, timeout counter.
//    Applies in any state: aborts an in-flight access with no response.
//  - States: IDLE, BUS, RDWAIT, RESP. cmd_ready = (state==IDLE), so 1 in the first cycle after reset.
//  - IDLE: on command accept, register addr/size/lane.
//      - Legal command -> BUS; avm_write or avm_read asserted from the next cycle.
//      - Illegal command -> RESP with rsp_err=1, rsp_rdata=0, no bus activity.
//  - Legality:
//      - byte: always legal.
//      - half: addr[0]==0.
//      - word: addr[1:0]==0.
//      - size 11: illegal.
//  - Byteenable and write data:
//      - byte: 4'b0001<<addr[1:0].
//      - half: addr[1] ? 4'b1100 : 4'b0011.
//      - word: 4'b1111.
//      - avm_writedata = size-masked cmd_wdata << 8*addr[1:0]; disabled lanes 0.
//      - avm_writedata is 0 for reads.
//  - BUS: avm_address/byteenable/writedata/write/read held stable while avm_waitrequest=1.
//      - Write: waitrequest=0 at posedge -> drop avm_write, go RESP (rsp_err=0).
//      - Read: waitrequest=0 at posedge -> drop avm_read, go RDWAIT.
//      - avm_readdatavalid is ignored in BUS.
//  - RDWAIT: on avm_readdatavalid -> RESP.
//      - rsp_rdata = (avm_readdata >> 8*addr[1:0]) masked to 8/16/32 bits.
//  - RESP: rsp_valid=1, data/err stable until rsp_ready.
//      - rsp_ready at posedge -> IDLE, rsp_valid=0.
//  - Latency:
//      - Write, no stall: accept edge N; avm_write high in cycle N+1; rsp_valid high cycle N+2.
//      - Read: rsp_valid rises the cycle after readdatavalid.
//  - Timeout (TIMEOUT>0): counter clears on entering BUS and increments each cycle in BUS/RDWAIT.
//      - Count reaching TIMEOUT -> drop avm_read/write, go RESP with rsp_err=1, rsp_rdata=0.
//      - Stale avm_readdatavalid arriving in IDLE/RESP is ignored.
//  - Exactly one outstanding transaction; no new command accepted until the response is consumed.
// TESTING
//  1. Hold reset_n=0 two cycles -> all avm_* = 0, rsp_valid=0; cmd_ready=1 the cycle after release.
//  2. Byte write addr=0x1002, wdata=0x000000AB, no stall
//     -> avm_address=0x1000, be=4'b0100, writedata=0x00AB0000, avm_write 1 cycle, rsp_err=0.
//  3. Half write addr=0x2006, wdata=0x1234, waitrequest high 3 cycles
//     -> avm_write high 4 cycles, be=4'b1100, writedata=0x12340000 stable throughout;
//        rsp_valid the following cycle.
//  4. Byte read addr=0x3003, readdatavalid 2 cycles after accept with readdata=0xDEADBEEF
//     -> rsp_rdata=0x000000DE; then word read at 0x3000 -> 0xDEADBEEF.
//  5. Half at addr=0x4001 and size=11 -> no avm_read/avm_write pulse, rsp_valid with rsp_err=1;
//     rsp_ready held low 5 cycles -> response held.
//  6. TIMEOUT=8, waitrequest stuck high on read -> avm_read drops after 8 cycles, rsp_err=1.
//     Separately, reset_n=0 during RDWAIT -> IDLE, no rsp_valid, late readdatavalid ignored.

Source files
------------

// File: rtl/avmm_lane_master.sv
// Avalon-MM master for single byte/half/word accesses to 32-bit byte-enabled registers.
// Turns right-justified commands into word-aligned, lane-steered bus cycles with pipelined reads.
module avmm_lane_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_size,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_write,
  output logic              avm_read,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  typedef enum logic [1:0] {StIdle, StBus, StRdWait, StResp} state_e;

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [1:0]          lane_q, lane_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   address_d;
  logic [3:0]          byteenable_d;
  logic                write_d, read_d;
  logic [31:0]         writedata_d;
  logic                rsp_valid_d, rsp_err_d;
  logic [31:0]         rsp_rdata_d;
  logic                cmd_legal;
  logic                timeout_hit;

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 32'h0000_00ff;
      2'b01:   return 32'h0000_ffff;
      default: return 32'hffff_ffff;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  always_comb begin
    case (cmd_size)
      2'b00:   cmd_legal = 1'b1;
      2'b01:   cmd_legal = ~cmd_addr[0];
      2'b10:   cmd_legal = (cmd_addr[1:0] == 2'b00);
      default: cmd_legal = 1'b0;
    endcase
  end

  // >= rather than == so a read that finishes its address phase on the last count still aborts
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= CntLast);
  assign cmd_ready   = (state_q == StIdle);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lane_d       = lane_q;
    size_d       = size_q;
    address_d    = avm_address;
    byteenable_d = avm_byteenable;
    write_d      = avm_write;
    read_d       = avm_read;
    writedata_d  = avm_writedata;
    rsp_valid_d  = rsp_valid;
    rsp_err_d    = rsp_err;
    rsp_rdata_d  = rsp_rdata;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          lane_d = cmd_addr[1:0];
          size_d = cmd_size;
          if (cmd_legal) begin
            state_d      = StBus;
            cnt_d        = '0;
            address_d    = {cmd_addr[ADDR_W-1:2], 2'b00};
            byteenable_d = lane_enables(cmd_size, cmd_addr[1:0]);
            write_d      = cmd_write;
            read_d       = ~cmd_write;
            writedata_d  = cmd_write ?
                           (cmd_wdata & size_mask(cmd_size)) << {cmd_addr[1:0], 3'b000} : 32'h0;
          end else begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end
        end
      end
      StBus: begin
        cnt_d = cnt_q + CntW'(1);
        if (!avm_waitrequest) begin
          write_d = 1'b0;
          read_d  = 1'b0;
          if (avm_write) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d = StRdWait;
          end
        end else if (timeout_hit) begin
          state_d     = StResp;
          write_d     = 1'b0;
          read_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end
      end
      StRdWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (avm_readdatavalid) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = (avm_readdata >> {lane_q, 3'b000}) & size_mask(size_q);
        end else if (timeout_hit) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      lane_q         <= '0;
      size_q         <= '0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      avm_writedata  <= '0;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_rdata      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lane_q         <= lane_d;
      size_q         <= size_d;
      avm_address    <= address_d;
      avm_byteenable <= byteenable_d;
      avm_write      <= write_d;
      avm_read       <= read_d;
      avm_writedata  <= writedata_d;
      rsp_valid      <= rsp_valid_d;
      rsp_err        <= rsp_err_d;
      rsp_rdata      <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_avmm_lane_master.sv
// Bench for avmm_lane_master: directed scenarios plus random accesses against an
// arithmetic byte-lane model of the expected bus cycle and response.
module tb_avmm_lane_master;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 8;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [1:0]        cmd_size = 2'b00;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [31:0]       cmd_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_write;
  logic              avm_read;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest = 1'b0;
  logic [31:0]       avm_readdata = '0;
  logic              avm_readdatavalid = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  avmm_lane_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_size          (cmd_size),
    .cmd_addr          (cmd_addr),
    .cmd_wdata         (cmd_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .avm_address       (avm_address),
    .avm_byteenable    (avm_byteenable),
    .avm_write         (avm_write),
    .avm_read          (avm_read),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clock = ~clock;

  // Reference model: an access touches 2**size bytes starting at byte (addr mod 4) of the word.
  function automatic bit model_legal(input logic [1:0] size, input logic [31:0] addr);
    int unsigned nb;
    if (size == 2'd3) return 1'b0;
    nb = 1 << size;
    return (addr % nb) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
    int unsigned nb;
    nb = 1 << size;
    return 4'(((1 << nb) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] addr,
                                              input logic [31:0] d);
    int unsigned nb;
    longint unsigned m, v;
    nb = 1 << size;
    m  = (64'd1 << (8 * nb)) - 1;
    v  = 64'(d);
    return 32'((v & m) << (8 * (addr % 4)));
  endfunction

  function automatic logic [31:0] model_rdata(input logic [1:0] size, input logic [31:0] addr,
                                              input logic [31:0] d);
    int unsigned nb;
    longint unsigned m, v;
    nb = 1 << size;
    m  = (64'd1 << (8 * nb)) - 1;
    v  = 64'(d);
    return 32'((v >> (8 * (addr % 4))) & m);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk_b("rsp_valid_clear", rsp_valid, 1'b0);
    chk_b("cmd_ready_back", cmd_ready, 1'b1);
  endtask

  // One full command: accept, bus phase with `stall` waitrequest cycles, read data `rd_delay`
  // cycles into the wait, response held `hold` cycles before consumption.
  task automatic txn(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] wdata, input int stall, input int rd_delay,
                     input logic [31:0] rd, input int hold);
    bit          legal;
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
    legal = model_legal(size, addr);
    chk_b("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_size  = size;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    step();
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    exp_rd    = 32'h0;
    if (!legal) begin
      chk_b("illegal_no_write", avm_write, 1'b0);
      chk_b("illegal_no_read", avm_read, 1'b0);
    end else begin
      exp_wd = wr ? model_wdata(size, addr, wdata) : 32'h0;
      for (int k = 0; k <= stall; k++) begin
        avm_waitrequest   = (k < stall);
        avm_readdatavalid = 1'($urandom_range(0, 1));
        avm_readdata      = $urandom;
        chk("avm_address", avm_address, addr & 32'hffff_fffc);
        chk("avm_byteenable", 32'(avm_byteenable), 32'(model_be(size, addr)));
        chk("avm_writedata", avm_writedata, exp_wd);
        chk_b("avm_write", avm_write, wr);
        chk_b("avm_read", avm_read, ~wr);
        chk_b("cmd_ready_busy", cmd_ready, 1'b0);
        chk_b("rsp_valid_busy", rsp_valid, 1'b0);
        step();
      end
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      chk_b("write_dropped", avm_write, 1'b0);
      chk_b("read_dropped", avm_read, 1'b0);
      if (!wr) begin
        for (int j = 0; j < rd_delay; j++) begin
          chk_b("rsp_valid_rdwait", rsp_valid, 1'b0);
          step();
        end
        chk_b("rsp_valid_rdwait", rsp_valid, 1'b0);
        avm_readdatavalid = 1'b1;
        avm_readdata      = rd;
        step();
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom;
        exp_rd = model_rdata(size, addr, rd);
      end
    end
    chk_b("rsp_valid", rsp_valid, 1'b1);
    chk_b("rsp_err", rsp_err, ~legal);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    for (int h = 0; h < hold; h++) begin
      avm_readdatavalid = 1'($urandom_range(0, 1));
      avm_readdata      = $urandom;
      step();
      chk_b("rsp_valid_hold", rsp_valid, 1'b1);
      chk_b("rsp_err_hold", rsp_err, ~legal);
      chk("rsp_rdata_hold", rsp_rdata, exp_rd);
      chk_b("bus_idle_hold", avm_write | avm_read, 1'b0);
    end
    avm_readdatavalid = 1'b0;
    consume();
  endtask

  initial begin
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;

    // Reset held for two edges
    step();
    step();
    chk_b("rst_avm_write", avm_write, 1'b0);
    chk_b("rst_avm_read", avm_read, 1'b0);
    chk("rst_avm_address", avm_address, 32'h0);
    chk("rst_avm_byteenable", 32'(avm_byteenable), 32'h0);
    chk("rst_avm_writedata", avm_writedata, 32'h0);
    chk_b("rst_rsp_valid", rsp_valid, 1'b0);
    chk_b("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    reset_n = 1'b1;
    chk_b("rst_cmd_ready", cmd_ready, 1'b1);

    // Directed accesses
    txn(1'b1, 2'b00, 32'h0000_1002, 32'h0000_00ab, 0, 0, 32'h0, 0);
    txn(1'b1, 2'b01, 32'h0000_2006, 32'h0000_1234, 3, 0, 32'h0, 1);
    txn(1'b0, 2'b00, 32'h0000_3003, 32'h0, 0, 0, 32'hdead_beef, 0);
    txn(1'b0, 2'b10, 32'h0000_3000, 32'h0, 0, 0, 32'hdead_beef, 0);
    txn(1'b0, 2'b01, 32'h0000_4001, 32'h0, 0, 0, 32'h0, 5);
    txn(1'b1, 2'b11, 32'h0000_4000, 32'hffff_ffff, 0, 0, 32'h0, 5);
    txn(1'b1, 2'b10, 32'h0000_4002, 32'h1111_2222, 0, 0, 32'h0, 0);

    // Waitrequest stuck high on a read: request stays up for TIMEOUT cycles, then aborts
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'b10; cmd_addr = 32'h0000_5000;
    step();
    cmd_valid = 1'b0;
    avm_waitrequest = 1'b1;
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      chk_b("to_read_held", avm_read, 1'b1);
      chk_b("to_no_rsp", rsp_valid, 1'b0);
      step();
    end
    chk_b("to_read_dropped", avm_read, 1'b0);
    chk_b("to_rsp_valid", rsp_valid, 1'b1);
    chk_b("to_rsp_err", rsp_err, 1'b1);
    chk("to_rsp_rdata", rsp_rdata, 32'h0);
    avm_waitrequest = 1'b0;
    consume();

    // Read data never returns: the timeout also covers the wait for readdatavalid
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'b00; cmd_addr = 32'h0000_5001;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      chk_b("to_rd_no_rsp", rsp_valid, 1'b0);
      step();
    end
    chk_b("to_rd_rsp_valid", rsp_valid, 1'b1);
    chk_b("to_rd_rsp_err", rsp_err, 1'b1);
    chk("to_rd_rsp_rdata", rsp_rdata, 32'h0);
    consume();

    // Reset while waiting for read data, then a stale readdatavalid
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'b10; cmd_addr = 32'h0000_6000;
    step();
    cmd_valid = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk_b("rst_mid_read", avm_read, 1'b0);
    chk_b("rst_mid_rsp", rsp_valid, 1'b0);
    chk_b("rst_mid_ready", cmd_ready, 1'b1);
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'h5555_aaaa;
    step();
    avm_readdatavalid = 1'b0;
    step();
    chk_b("stale_rdv_rsp", rsp_valid, 1'b0);
    chk_b("stale_rdv_ready", cmd_ready, 1'b1);
    chk("stale_rdv_rdata", rsp_rdata, 32'h0);

    // Random accesses, bus stalls kept well inside the timeout window
    for (int t = 0; t < 60; t++) begin
      wr   = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
      txn(wr, size, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), $urandom,
          $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
